// File: rtl/melody_sequencer.sv
// Melody sequencer: steps a per-song note ROM and drives a square-wave
// speaker with per-note durations, articulation gaps, pause and song change.
module melody_sequencer #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_CLKS = 12_500_000,
  parameter int unsigned GAP_CLKS  = 1_250_000,
  parameter int unsigned SONG_LEN  = 32
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       play_stop,
  input  logic [4:0] song_sel,
  output logic       speaker,
  output logic       busy,
  output logic [4:0] note_idx,
  output logic       song_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    PAUSE
  } state_t;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_END  = 4'd15;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] dur_q, dur_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] half_q, half_d;
  logic [3:0]  note_q, note_d;
  logic        tone_q, tone_d;
  logic        spk_q, spk_d;
  logic        done_q, done_d;
  logic [4:0]  sel_q;

  logic [2:0]  song;
  logic [6:0]  entry;
  logic [3:0]  ent_note;
  logic [2:0]  ent_dur;
  logic [2:0]  dur_eff;
  logic [4:0]  idx_inc;

  function automatic logic [6:0] rom(
    input logic [2:0] s,
    input logic [4:0] i
  );
    rom = {NOTE_END, 3'd0};
    case (s)
      3'd0: case (i)
        5'd0:  rom = {4'd3, 3'd1};
        5'd1:  rom = {4'd3, 3'd1};
        5'd2:  rom = {4'd3, 3'd2};
        5'd3:  rom = {4'd3, 3'd1};
        5'd4:  rom = {4'd3, 3'd1};
        5'd5:  rom = {4'd3, 3'd2};
        5'd6:  rom = {4'd3, 3'd1};
        5'd7:  rom = {4'd5, 3'd1};
        5'd8:  rom = {4'd1, 3'd1};
        5'd9:  rom = {4'd2, 3'd1};
        5'd10: rom = {4'd3, 3'd4};
        default: rom = {NOTE_END, 3'd0};
      endcase
      3'd1: case (i)
        5'd0:  rom = {4'd8, 3'd2};
        5'd1:  rom = {4'd10, 3'd2};
        5'd2:  rom = {4'd12, 3'd2};
        5'd3:  rom = {4'd8, 3'd1};
        5'd4:  rom = {NOTE_REST, 3'd1};
        default: rom = {NOTE_END, 3'd0};
      endcase
      3'd2: case (i)
        5'd0:  rom = {4'd6, 3'd1};
        5'd1:  rom = {4'd7, 3'd1};
        5'd2:  rom = {4'd8, 3'd2};
        default: rom = {NOTE_END, 3'd0};
      endcase
      3'd3: case (i)
        5'd0:  rom = {4'd5, 3'd3};
        5'd1:  rom = {4'd4, 3'd1};
        5'd2:  rom = {NOTE_REST, 3'd0};
        5'd3:  rom = {4'd3, 3'd2};
        default: rom = {NOTE_END, 3'd0};
      endcase
      3'd4: case (i)
        5'd0:  rom = {4'd9, 3'd2};
        5'd1:  rom = {4'd8, 3'd2};
        5'd2:  rom = {4'd7, 3'd4};
        default: rom = {NOTE_END, 3'd0};
      endcase
      default: rom = {NOTE_END, 3'd0};
    endcase
  endfunction

  function automatic logic [31:0] half_of(input logic [3:0] n);
    case (n)
      4'd1:  half_of = 32'(CLK_HZ / (2 * 262));
      4'd2:  half_of = 32'(CLK_HZ / (2 * 294));
      4'd3:  half_of = 32'(CLK_HZ / (2 * 330));
      4'd4:  half_of = 32'(CLK_HZ / (2 * 349));
      4'd5:  half_of = 32'(CLK_HZ / (2 * 392));
      4'd6:  half_of = 32'(CLK_HZ / (2 * 440));
      4'd7:  half_of = 32'(CLK_HZ / (2 * 494));
      4'd8:  half_of = 32'(CLK_HZ / (2 * 523));
      4'd9:  half_of = 32'(CLK_HZ / (2 * 587));
      4'd10: half_of = 32'(CLK_HZ / (2 * 659));
      4'd11: half_of = 32'(CLK_HZ / (2 * 698));
      4'd12: half_of = 32'(CLK_HZ / (2 * 784));
      4'd13: half_of = 32'(CLK_HZ / (2 * 880));
      4'd14: half_of = 32'(CLK_HZ / (2 * 988));
      default: half_of = 32'd1;
    endcase
  endfunction

  // Lowest set bit wins when several songs are selected
  always_comb begin
    song = 3'd0;
    priority case (1'b1)
      sel_q[0]: song = 3'd0;
      sel_q[1]: song = 3'd1;
      sel_q[2]: song = 3'd2;
      sel_q[3]: song = 3'd3;
      sel_q[4]: song = 3'd4;
      default:  song = 3'd0;
    endcase
  end

  assign entry    = rom(song, idx_q);
  assign ent_note = entry[6:3];
  assign ent_dur  = entry[2:0];
  assign dur_eff  = (ent_dur == 3'd0) ? 3'd1 : ent_dur;
  assign idx_inc  = (idx_q == 5'(SONG_LEN - 1)) ? 5'd0 : idx_q + 5'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    tcnt_d  = tcnt_q;
    half_d  = half_q;
    note_d  = note_q;
    tone_d  = tone_q;
    spk_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = 5'd0;
        if (play_stop && song_sel != 5'd0) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (ent_note == NOTE_END) begin
          done_d = 1'b1;
          idx_d  = 5'd0;
        end else begin
          dur_d   = 32'(dur_eff) * 32'(TICK_CLKS);
          tcnt_d  = 32'd0;
          tone_d  = 1'b0;
          note_d  = ent_note;
          half_d  = half_of(ent_note);
          state_d = PLAY;
        end
      end
      PLAY: begin
        dur_d = dur_q - 32'd1;
        if (tcnt_q >= half_q - 32'd1) begin
          tone_d = ~tone_q;
          tcnt_d = 32'd0;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
        spk_d = tone_d && (note_q != NOTE_REST) &&
                (dur_d > 32'(GAP_CLKS));
        if (dur_q <= 32'd1) begin
          idx_d   = idx_inc;
          spk_d   = 1'b0;
          state_d = LOAD;
        end else if (!play_stop) begin
          spk_d   = 1'b0;
          tone_d  = 1'b0;
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (play_stop) begin
          state_d = PLAY;
        end
      end
    endcase
    // Song change or deselect overrides whatever the state wanted
    if (state_q != IDLE) begin
      if (song_sel == 5'd0) begin
        state_d = IDLE;
        idx_d   = 5'd0;
        spk_d   = 1'b0;
        tone_d  = 1'b0;
        done_d  = 1'b0;
      end else if (song_sel != sel_q) begin
        state_d = play_stop ? LOAD : IDLE;
        idx_d   = 5'd0;
        spk_d   = 1'b0;
        tone_d  = 1'b0;
        done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      dur_q   <= 32'd0;
      tcnt_q  <= 32'd0;
      half_q  <= 32'd1;
      note_q  <= NOTE_REST;
      tone_q  <= 1'b0;
      spk_q   <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      tcnt_q  <= tcnt_d;
      half_q  <= half_d;
      note_q  <= note_d;
      tone_q  <= tone_d;
      spk_q   <= spk_d;
      done_q  <= done_d;
      sel_q   <= song_sel;
    end
  end

  assign speaker   = spk_q;
  assign busy      = (state_q == PLAY);
  assign note_idx  = idx_q;
  assign song_done = done_q;

endmodule
